// File: rtl/cache_pkg.sv
// Shared types and field helpers for the direct-mapped data cache controller.
// Address layout: [2:0] byte, [4:3] word, [8:5] index, [ADDR_W-1:9] tag.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        REFILL
    } state_e;

    localparam int INDEX_W   = 4;
    localparam int OFFSET_W  = 5;
    localparam int LINE_W    = 256;
    localparam int WORD_W    = 64;
    localparam int WSEL_W    = 2;
    localparam int NUM_LINES = 16;

    function automatic logic [INDEX_W-1:0] get_index(input logic [8:0] lo);
        return lo[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [WSEL_W-1:0] get_wsel(input logic [8:0] lo);
        return lo[3 +: WSEL_W];
    endfunction

    function automatic logic [63:0] get_tag(input logic [63:0] addr);
        return addr >> (OFFSET_W + INDEX_W);
    endfunction

    function automatic logic [WORD_W-1:0] get_word(
        input logic [LINE_W-1:0] line,
        input logic [WSEL_W-1:0] sel
    );
        return line[sel*WORD_W +: WORD_W];
    endfunction

    function automatic logic [LINE_W-1:0] put_word(
        input logic [LINE_W-1:0] line,
        input logic [WSEL_W-1:0] sel,
        input logic [WORD_W-1:0] word
    );
        logic [LINE_W-1:0] res;
        res = line;
        res[sel*WORD_W +: WORD_W] = word;
        return res;
    endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Per-line tag/valid/dirty state for the data cache.
// Valid and dirty clear on reset; tags hold whatever was last filled.
module cache_tag_store
    import cache_pkg::*;
#(
    parameter int TAG_W = 23,
    parameter int LINES = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] idx_i,
    output logic [TAG_W-1:0]   tag_o,
    output logic               valid_o,
    output logic               dirty_o,
    input  logic               set_dirty_i,
    input  logic               clr_dirty_i,
    input  logic               fill_i,
    input  logic [TAG_W-1:0]   fill_tag_i
);

    logic [TAG_W-1:0] tag_q [LINES];
    logic [TAG_W-1:0] tag_d [LINES];
    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;

    assign tag_o   = tag_q[idx_i];
    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];

    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_i) begin
            tag_d[idx_i]   = fill_tag_i;
            valid_d[idx_i] = 1'b1;
            dirty_d[idx_i] = 1'b0;
        end
        if (set_dirty_i) begin
            dirty_d[idx_i] = 1'b1;
        end
        if (clr_dirty_i) begin
            dirty_d[idx_i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tags need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk_i) begin
        tag_q <= tag_d;
    end

endmodule

// File: rtl/cache_ctrl.sv
// Write-back, write-allocate controller for a 16 x 256-bit direct-mapped cache.
// Hits complete in the request cycle; misses block on a line-wide memory handshake.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINES  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [63:0]       cpu_wdata_i,
    output logic [63:0]       cpu_rdata_o,
    output logic              cpu_ready_o,
    output logic [3:0]        data_req_index_o,
    output logic              data_req_we_o,
    output logic [255:0]      data_write_o,
    input  logic [255:0]      data_read_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [255:0]      mem_wdata_o,
    input  logic [255:0]      mem_rdata_i,
    input  logic              mem_ack_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int TAG_W = ADDR_W - 9;

    state_e state_q, state_d;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    logic [INDEX_W-1:0] idx;
    logic [WSEL_W-1:0]  wsel;
    logic [TAG_W-1:0]   req_tag;
    logic [TAG_W-1:0]   line_tag;
    logic               line_valid;
    logic               line_dirty;
    logic               hit;
    logic               set_dirty;
    logic               clr_dirty;
    logic               fill;

    assign idx     = get_index(cpu_addr_i[8:0]);
    assign wsel    = get_wsel(cpu_addr_i[8:0]);
    assign req_tag = TAG_W'(get_tag(64'(cpu_addr_i)));
    assign hit     = cpu_req_i && line_valid && (line_tag == req_tag);

    assign data_req_index_o = idx;
    assign cpu_rdata_o      = get_word(data_read_i, wsel);
    assign mem_wdata_o      = data_read_i;
    assign hit_cnt_o        = hit_cnt_q;
    assign miss_cnt_o       = miss_cnt_q;

    cache_tag_store #(
        .TAG_W (TAG_W),
        .LINES (LINES)
    ) u_tags (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (idx),
        .tag_o       (line_tag),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .set_dirty_i (set_dirty),
        .clr_dirty_i (clr_dirty),
        .fill_i      (fill),
        .fill_tag_i  (req_tag)
    );

    always_comb begin
        state_d       = state_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        cpu_ready_o   = 1'b0;
        data_req_we_o = 1'b0;
        data_write_o  = '0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        set_dirty     = 1'b0;
        clr_dirty     = 1'b0;
        fill          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    cpu_ready_o = 1'b1;
                    hit_cnt_d   = hit_cnt_q + 32'd1;
                    if (cpu_we_i) begin
                        data_req_we_o = 1'b1;
                        data_write_o  = put_word(data_read_i, wsel, cpu_wdata_i);
                        set_dirty     = 1'b1;
                    end
                end else if (cpu_req_i) begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    state_d    = (line_valid && line_dirty) ? WB : REFILL;
                end
            end
            WB: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = {line_tag, idx, 5'b0};
                if (mem_ack_i) begin
                    clr_dirty = 1'b1;
                    state_d   = REFILL;
                end
            end
            REFILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {req_tag, idx, 5'b0};
                // Fill writes the array directly; the next IDLE cycle replays as a hit.
                if (mem_ack_i) begin
                    data_req_we_o = 1'b1;
                    data_write_o  = mem_rdata_i;
                    fill          = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: directed vector table, reset-mid-miss sequence and
// random accesses checked against a word-level memory reference model.
module tb_cache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [63:0]  cpu_wdata_i;
    logic [63:0]  cpu_rdata_o;
    logic         cpu_ready_o;
    logic [3:0]   data_req_index_o;
    logic         data_req_we_o;
    logic [255:0] data_write_o;
    logic [255:0] data_read_i;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i;
    logic         mem_ack_i;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    cache_ctrl #(.ADDR_W(32), .LINES(16)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .cpu_req_i        (cpu_req_i),
        .cpu_we_i         (cpu_we_i),
        .cpu_addr_i       (cpu_addr_i),
        .cpu_wdata_i      (cpu_wdata_i),
        .cpu_rdata_o      (cpu_rdata_o),
        .cpu_ready_o      (cpu_ready_o),
        .data_req_index_o (data_req_index_o),
        .data_req_we_o    (data_req_we_o),
        .data_write_o     (data_write_o),
        .data_read_i      (data_read_i),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_rdata_i      (mem_rdata_i),
        .mem_ack_i        (mem_ack_i),
        .hit_cnt_o        (hit_cnt_o),
        .miss_cnt_o       (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Data array: combinational read, write on the clock edge.
    logic [255:0] darr [16];
    assign data_read_i = darr[data_req_index_o];
    always @(posedge clk_i) begin
        if (data_req_we_o) darr[data_req_index_o] <= data_write_o;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: architectural word memory, backing memory and residency.
    logic [63:0] arch [logic [31:0]];
    logic [63:0] bmem [logic [31:0]];
    bit          r_valid [16];
    bit          r_dirty [16];
    int unsigned r_tag [16];
    logic [31:0] e_hit;
    logic [31:0] e_miss;

    function automatic logic [63:0] init_word(input logic [31:0] a);
        return {a ^ 32'h5A5A_1234, ~a};
    endfunction

    function automatic logic [63:0] arch_rd(input logic [31:0] a);
        return arch.exists(a) ? arch[a] : init_word(a);
    endfunction

    function automatic logic [63:0] bmem_rd(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : init_word(a);
    endfunction

    function automatic logic [255:0] arch_line(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[k*64 +: 64] = arch_rd(la + 32'(k*8));
        return l;
    endfunction

    function automatic logic [255:0] bmem_line(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[k*64 +: 64] = bmem_rd(la + 32'(k*8));
        return l;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            r_valid[k] = 1'b0;
            r_dirty[k] = 1'b0;
        end
        e_hit  = '0;
        e_miss = '0;
        arch.delete();
        foreach (bmem[k]) arch[k] = bmem[k];
    endtask

    task automatic access(
        input  logic        we,
        input  logic [31:0] addr,
        input  logic [63:0] wd,
        input  int          dly,
        output logic [63:0] rd,
        output int          nwb,
        output int          nrf,
        output int          cyc
    );
        logic [31:0]  wa, la, vla;
        logic [255:0] ml;
        int           idx, w, ewb, emiss;
        int unsigned  tag;
        bit           done;
        wa    = addr & ~32'h7;
        la    = addr & ~32'h1F;
        idx   = int'(addr[8:5]);
        tag   = int'(addr[31:9]);
        emiss = (r_valid[idx] && r_tag[idx] == tag) ? 0 : 1;
        ewb   = (emiss == 1 && r_valid[idx] && r_dirty[idx]) ? 1 : 0;
        vla   = 32'((r_tag[idx] << 9) | (idx << 5));
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wd;
        nwb = 0; nrf = 0; cyc = 0; w = 0; done = 1'b0; rd = '0;
        while (!done && cyc < 64) begin
            @(negedge clk_i);
            mem_ack_i   = 1'b0;
            mem_rdata_i = '0;
            cyc++;
            if (cpu_ready_o) begin
                done = 1'b1;
                rd   = cpu_rdata_o;
                chk("index", 256'(data_req_index_o), 256'(addr[8:5]));
                if (we) begin
                    ml = arch_line(la);
                    ml[addr[4:3]*64 +: 64] = wd;
                    chk("store_we", 256'(data_req_we_o), 256'(1));
                    chk("store_line", data_write_o, ml);
                end else begin
                    chk("load_we", 256'(data_req_we_o), 256'(0));
                    chk("load_data", 256'(cpu_rdata_o), 256'(arch_rd(wa)));
                end
            end else if (mem_req_o) begin
                if (ewb == 1 && nwb == 0) begin
                    chk("wb_we", 256'(mem_we_o), 256'(1));
                    chk("wb_addr", 256'(mem_addr_o), 256'(vla));
                end else begin
                    chk("rf_we", 256'(mem_we_o), 256'(0));
                    chk("rf_addr", 256'(mem_addr_o), 256'(la));
                end
                if (w == dly) begin
                    w = 0;
                    mem_ack_i = 1'b1;
                    if (mem_we_o) begin
                        nwb++;
                        chk("wb_data", mem_wdata_o, arch_line(mem_addr_o));
                        for (int k = 0; k < 4; k++)
                            bmem[mem_addr_o + 32'(k*8)] = mem_wdata_o[k*64 +: 64];
                    end else begin
                        nrf++;
                        mem_rdata_i = bmem_line(mem_addr_o);
                    end
                end else begin
                    w++;
                end
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: addr %0h no ready within %0d cycles", addr, cyc);
        end
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
        mem_ack_i = 1'b0;
        if (emiss == 1) begin
            e_miss++;
            r_valid[idx] = 1'b1;
            r_tag[idx]   = tag;
            r_dirty[idx] = 1'b0;
        end
        e_hit++;
        if (we) begin
            arch[wa]     = wd;
            r_dirty[idx] = 1'b1;
        end
        chk("wb_count", 256'(nwb), 256'(ewb));
        chk("rf_count", 256'(nrf), 256'(emiss));
        chk("latency", 256'(cyc), 256'(1 + emiss + (ewb + emiss) * (dly + 1)));
        chk("hit_cnt", 256'(hit_cnt_o), 256'(e_hit));
        chk("miss_cnt", 256'(miss_cnt_o), 256'(e_miss));
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [63:0] wd;
        int          dly;
        logic [63:0] erd;
        int          ewb;
        int          erf;
        int          ecyc;
        logic [31:0] ehit;
        logic [31:0] emiss;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        int          nwb, nrf, cyc;
        logic [31:0] ra;

        rst_i       = 1'b1;
        cpu_req_i   = 1'b0;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = '0;
        cpu_wdata_i = '0;
        mem_rdata_i = '0;
        mem_ack_i   = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", 256'(cpu_ready_o), 256'(0));
        chk("rst_mem_req", 256'(mem_req_o), 256'(0));
        chk("rst_mem_we", 256'(mem_we_o), 256'(0));
        chk("rst_data_we", 256'(data_req_we_o), 256'(0));
        chk("rst_hit_cnt", 256'(hit_cnt_o), 256'(0));
        chk("rst_miss_cnt", 256'(miss_cnt_o), 256'(0));
        rst_i = 1'b0;

        // Stray ack while idle must be ignored.
        @(negedge clk_i);
        mem_ack_i = 1'b1;
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
        chk("idle_ack_req", 256'(mem_req_o), 256'(0));
        chk("idle_ack_miss", 256'(miss_cnt_o), 256'(0));

        bmem[32'h40] = 64'h1111;
        bmem[32'h48] = 64'h2222;
        bmem[32'h50] = 64'h3333;
        bmem[32'h58] = 64'h4444;
        model_reset();

        vecs[0] = '{1'b0, 32'h040, 64'h0,    2, 64'h1111,             0, 1, 5, 32'd1, 32'd1};
        vecs[1] = '{1'b0, 32'h048, 64'h0,    0, 64'h2222,             0, 0, 1, 32'd2, 32'd1};
        vecs[2] = '{1'b1, 32'h050, 64'hDEAD, 0, 64'h0,                0, 0, 1, 32'd3, 32'd1};
        vecs[3] = '{1'b0, 32'h050, 64'h0,    0, 64'hDEAD,             0, 0, 1, 32'd4, 32'd1};
        vecs[4] = '{1'b0, 32'h240, 64'h0,    1, init_word(32'h240),   1, 1, 6, 32'd5, 32'd2};
        vecs[5] = '{1'b0, 32'h440, 64'h0,    0, init_word(32'h440),   0, 1, 3, 32'd6, 32'd3};
        vecs[6] = '{1'b0, 32'h240, 64'h0,    3, init_word(32'h240),   0, 1, 6, 32'd7, 32'd4};

        for (int i = 0; i < 7; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].dly, rd, nwb, nrf, cyc);
            if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), 256'(rd), 256'(vecs[i].erd));
            chk($sformatf("vec%0d_wb", i), 256'(nwb), 256'(vecs[i].ewb));
            chk($sformatf("vec%0d_rf", i), 256'(nrf), 256'(vecs[i].erf));
            chk($sformatf("vec%0d_cyc", i), 256'(cyc), 256'(vecs[i].ecyc));
            chk($sformatf("vec%0d_hits", i), 256'(hit_cnt_o), 256'(vecs[i].ehit));
            chk($sformatf("vec%0d_miss", i), 256'(miss_cnt_o), 256'(vecs[i].emiss));
        end
        chk("wb_line_word2", 256'(bmem_rd(32'h50)), 256'(64'hDEAD));

        // Reset while a refill is outstanding.
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h640;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rf_pend_req", 256'(mem_req_o), 256'(1));
        chk("rf_pend_we", 256'(mem_we_o), 256'(0));
        chk("rf_pend_addr", 256'(mem_addr_o), 256'(32'h640));
        rst_i     = 1'b1;
        cpu_req_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("rst_mid_req", 256'(mem_req_o), 256'(0));
        chk("rst_mid_ready", 256'(cpu_ready_o), 256'(0));
        chk("rst_mid_hits", 256'(hit_cnt_o), 256'(0));
        chk("rst_mid_miss", 256'(miss_cnt_o), 256'(0));
        model_reset();
        access(1'b0, 32'h240, 64'h0, 1, rd, nwb, nrf, cyc);
        chk("rst_reload_rf", 256'(nrf), 256'(1));
        chk("rst_reload_data", 256'(rd), 256'(init_word(32'h240)));

        for (int i = 0; i < 400; i++) begin
            ra = 32'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5)
                     | $urandom_range(0, 31));
            access(1'($urandom_range(0, 1)), ra, {$urandom, $urandom},
                   int'($urandom_range(0, 3)), rd, nwb, nrf, cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
